// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- sequencer for one single-port MUT with first-fail capture
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           fail_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, SETUP, OP_RD, OP_WR, DRAIN, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY);
  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};
  state_t                r_state;
  logic [2:0]            r_elem;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we, r_busy, r_done, r_drain;
  logic [15:0]           r_fail_cnt;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [2:0]            r_fail_elem;
  logic [DATA_WIDTH-1:0] r_fail_exp, r_fail_act;
  logic                  r_p0_v, r_p1_v;
  logic [ADDR_WIDTH-1:0] r_p0_addr, r_p1_addr;
  logic [2:0]            r_p0_elem, r_p1_elem;
  logic [DATA_WIDTH-1:0] r_p0_exp, r_p1_exp;
  logic                  w_last, w_mis;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [2:0]            w_nelem;
  function automatic logic up(input logic [2:0] e);
    return e < 3'd3;
  endfunction
  function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
    return up(e) ? '0 : LAST;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] wr_bg(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? ONES : '0;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] rd_bg(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? ONES : '0;
  endfunction
  assign w_last  = r_addr == (up(r_elem) ? LAST : '0);
  assign w_next  = up(r_elem) ? r_addr + 1'b1 : r_addr - 1'b1;
  assign w_nelem = r_elem + 3'd1;
  assign w_mis   = r_p1_v && (mem_rdata != r_p1_exp);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_elem      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_drain     <= 1'b0;
      r_fail_cnt  <= '0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_exp  <= '0;
      r_fail_act  <= '0;
      r_p0_v      <= 1'b0;
      r_p1_v      <= 1'b0;
      r_p0_addr   <= '0;
      r_p1_addr   <= '0;
      r_p0_elem   <= '0;
      r_p1_elem   <= '0;
      r_p0_exp    <= '0;
      r_p1_exp    <= '0;
    end else begin
      // the read is sampled by the MUT at the end of OP_RD; its data returns two edges later
      r_p0_v    <= r_state == OP_RD;
      r_p0_addr <= r_addr;
      r_p0_elem <= r_elem;
      r_p0_exp  <= rd_bg(r_elem);
      r_p1_v    <= r_p0_v;
      r_p1_addr <= r_p0_addr;
      r_p1_elem <= r_p0_elem;
      r_p1_exp  <= r_p0_exp;
      if (w_mis) begin
        r_fail_cnt <= r_fail_cnt + 16'(r_fail_cnt != 16'hFFFF);
        if (r_fail_cnt == '0) begin
          r_fail_addr <= r_p1_addr;
          r_fail_elem <= r_p1_elem;
          r_fail_exp  <= r_p1_exp;
          r_fail_act  <= mem_rdata;
        end
      end
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state     <= SETUP;
          r_elem      <= '0;
          r_addr      <= first_addr(3'd0);
          r_wdata     <= wr_bg(3'd0);
          r_we        <= 1'b0;
          r_busy      <= 1'b1;
          r_done      <= 1'b0;
          r_fail_cnt  <= '0;
          r_fail_addr <= '0;
          r_fail_elem <= '0;
          r_fail_exp  <= '0;
          r_fail_act  <= '0;
        end
        SETUP: begin
          r_state <= r_elem == 3'd0 ? OP_WR : OP_RD;
          r_we    <= r_elem == 3'd0;
        end
        OP_RD: if (r_elem != 3'd5) begin
          r_state <= OP_WR;
          r_we    <= 1'b1;
        end else if (w_last) begin
          r_state <= DRAIN;
          r_drain <= 1'b0;
        end else r_addr <= w_next;
        OP_WR: if (w_last) begin
          r_state <= SETUP;
          r_elem  <= w_nelem;
          r_addr  <= first_addr(w_nelem);
          r_wdata <= wr_bg(w_nelem);
          r_we    <= 1'b0;
        end else begin
          r_addr  <= w_next;
          r_state <= r_elem == 3'd0 ? OP_WR : OP_RD;
          r_we    <= r_elem == 3'd0;
        end
        DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_done && (r_fail_cnt == '0);
  assign fail_cnt       = r_fail_cnt;
  assign fail_addr      = r_fail_addr;
  assign fail_elem      = r_fail_elem;
  assign fail_exp       = r_fail_exp;
  assign fail_act       = r_fail_act;
  assign mem_write_read = r_we;
  assign mem_address    = r_addr;
  assign mem_wdata      = r_wdata;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: faulty-MUT model plus table, hand and random March C- runs
module tb_mbist_march_ctrl;
  localparam int N = 16;
  localparam int LAT = 8 + 10 * N;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, pass, mem_write_read;
  logic [15:0] fail_cnt;
  logic [3:0] fail_addr, mem_address;
  logic [2:0] fail_elem;
  logic [7:0] fail_exp, fail_act, mem_wdata, mem_rdata;
  int errors = 0, checks = 0;
  logic sa_en = 1'b0, sa_val = 1'b0, cp_en = 1'b0;
  int sa_addr = 0, sa_bit = 0;
  logic [7:0] mem [16];
  logic [7:0] wq, q1, q2;
  typedef struct packed {logic we; logic [3:0] a; logic [7:0] d;} bus_t;
  typedef struct {
    logic sa_en; int sa_addr; int sa_bit; logic sa_val; logic cp_en;
    logic [15:0] cnt; logic [3:0] fa; logic [2:0] fe; logic [7:0] fx; logic [7:0] fac;
  } vec_t;
  bus_t tr[$];
  vec_t vt[6];
  bus_t m3[5];

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_exp(fail_exp), .fail_act(fail_act), .mem_write_read(mem_write_read),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // stuck-at bit plus a coupling fault on addr 7 sensitised by neighbours 6=FF, 8=00
  function automatic logic [7:0] apply_fault(input int a, input logic [7:0] v, input logic [7:0] n6, input logic [7:0] n8);
    logic [7:0] r = v;
    if (sa_en && a == sa_addr) r[sa_bit] = sa_val;
    if (cp_en && a == 7 && n6 == 8'hFF && n8 == 8'h00) r[0] = ~r[0];
    return r;
  endfunction

  // MUT: wdata registered one cycle ahead, two-cycle read latency
  always @(posedge clk) begin
    wq <= mem_wdata;
    if (mem_write_read) mem[mem_address] <= wq;
    q1 <= apply_fault(int'(mem_address), mem[mem_address], mem[6], mem[8]);
    q2 <= q1;
  end
  assign mem_rdata = q2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bg(input int e);
    return (e == 1 || e == 3) ? 8'hFF : 8'h00;
  endfunction

  // March C- executed as an algorithm over an array
  task automatic model(output logic [15:0] cnt, output logic [3:0] fa, output logic [2:0] fe,
                       output logic [7:0] fx, output logic [7:0] fac);
    logic [7:0] m [16];
    logic [7:0] r, ex;
    int a;
    cnt = 0; fa = 0; fe = 0; fx = 0; fac = 0;
    for (int i = 0; i < N; i++) m[i] = 8'($urandom);
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        a = e < 3 ? i : N - 1 - i;
        if (e != 0) begin
          r = apply_fault(a, m[a], m[6], m[8]);
          ex = (e == 2 || e == 4) ? 8'hFF : 8'h00;
          if (r != ex) begin
            if (cnt == 0) begin fa = 4'(a); fe = 3'(e); fx = ex; fac = r; end
            cnt++;
          end
        end
        if (e != 5) m[a] = bg(e);
      end
  endtask

  task automatic build_trace();
    int a;
    tr.delete();
    for (int e = 0; e < 6; e++) begin
      tr.push_back(bus_t'{1'b0, (e < 3) ? 4'd0 : 4'd15, bg(e)});
      for (int i = 0; i < N; i++) begin
        a = e < 3 ? i : N - 1 - i;
        if (e != 0) tr.push_back(bus_t'{1'b0, 4'(a), bg(e)});
        if (e != 5) tr.push_back(bus_t'{1'b1, 4'(a), bg(e)});
      end
    end
  endtask

  task automatic run_test(input bit hold, input string nm, input logic [15:0] cnt, input logic [3:0] fa,
                          input logic [2:0] fe, input logic [7:0] fx, input logic [7:0] fac);
    int t;
    bus_t b;
    build_trace();
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (t = 0; t <= 400; t++) begin
      b = bus_t'{mem_write_read, mem_address, mem_wdata};
      if (t == 0) chk({nm, " busy@start"}, {busy, done}, 2'b10);
      if (t < tr.size()) chk($sformatf("%s bus t=%0d", nm, t), b, tr[t]);
      if (t >= 83 && t <= 87) chk($sformatf("%s M3 bus t=%0d", nm, t), b, m3[t-83]);
      if (done) break;
      @(negedge clk);
    end
    chk({nm, " latency"}, t, LAT);
    chk({nm, " fail_cnt"}, fail_cnt, cnt);
    chk({nm, " pass"}, {pass, busy}, {cnt == 0, 1'b0});
    chk({nm, " fail_addr"}, fail_addr, fa);
    chk({nm, " fail_elem"}, fail_elem, fe);
    chk({nm, " fail_exp"}, fail_exp, fx);
    chk({nm, " fail_act"}, fail_act, fac);
  endtask

  initial begin
    logic [15:0] c;
    logic [3:0] fa;
    logic [2:0] fe;
    logic [7:0] fx, fac;
    vt[0] = '{0, 0, 0, 0, 0, 16'd0, 4'd0, 3'd0, 8'h00, 8'h00};
    vt[1] = '{1, 3, 5, 0, 0, 16'd2, 4'd3, 3'd2, 8'hFF, 8'hDF};
    vt[2] = '{1, 0, 0, 1, 0, 16'd3, 4'd0, 3'd1, 8'h00, 8'h01};
    vt[3] = '{1, 15, 7, 0, 0, 16'd2, 4'd15, 3'd2, 8'hFF, 8'h7F};
    vt[4] = '{0, 0, 0, 0, 1, 16'd2, 4'd7, 3'd1, 8'h00, 8'h01};
    vt[5] = '{1, 12, 7, 0, 1, 16'd4, 4'd7, 3'd1, 8'h00, 8'h01};
    m3[0] = bus_t'{1'b0, 4'd15, 8'hFF};
    m3[1] = bus_t'{1'b0, 4'd15, 8'hFF};
    m3[2] = bus_t'{1'b1, 4'd15, 8'hFF};
    m3[3] = bus_t'{1'b0, 4'd14, 8'hFF};
    m3[4] = bus_t'{1'b1, 4'd14, 8'hFF};
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {busy, done, pass}, 3'b000);
    chk("reset fails", {fail_cnt, fail_addr, fail_elem, fail_exp, fail_act}, '0);
    chk("reset bus", {mem_write_read, mem_address, mem_wdata}, '0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle", {busy, done}, 2'b00);
    for (int k = 0; k < 6; k++) begin
      sa_en = vt[k].sa_en; sa_addr = vt[k].sa_addr; sa_bit = vt[k].sa_bit;
      sa_val = vt[k].sa_val; cp_en = vt[k].cp_en;
      run_test(1'b0, $sformatf("vec%0d", k), vt[k].cnt, vt[k].fa, vt[k].fe, vt[k].fx, vt[k].fac);
      @(negedge clk);
    end
    sa_en = 1'b0; cp_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort", {busy, done, mem_write_read}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    run_test(1'b0, "after_abort", 16'd0, 4'd0, 3'd0, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) begin
      sa_en = 1'($urandom_range(0, 1)); sa_addr = $urandom_range(0, 15);
      sa_bit = $urandom_range(0, 7); sa_val = 1'($urandom_range(0, 1));
      cp_en = 1'($urandom_range(0, 1));
      model(c, fa, fe, fx, fac);
      run_test(1'b0, $sformatf("rand%0d", k), c, fa, fe, fx, fac);
      @(negedge clk);
    end
    sa_en = 1'b0; cp_en = 1'b0;
    run_test(1'b1, "held_start", 16'd0, 4'd0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rearm", {busy, done}, 2'b10);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
